axi4_wr_fifo_sequencer: RTL and testbench

//  Sequences the AW, W and B FIFOs of one AXI4 write path onto a master-side AXI4 write port.
//  - Pops AW descriptors and issues them downstream.
//  - Releases exactly AWLEN+1 W beats per issued burst, in AW order, and generates WLAST.
//  - Forwards B responses into the B FIFO and bounds outstanding bursts.

---
 rtl/axi4_wr_seq_pkg.sv | 20 ++
 rtl/axi4_wr_len_fifo.sv | 85 ++++++++
 rtl/axi4_wr_fifo_sequencer.sv | 163 ++++++++++++++++
 tb/tb_axi4_wr_fifo_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_wr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_wr_seq_pkg
// Brief    : Shared types and helpers for the AXI4 write-path sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package axi4_wr_seq_pkg;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_DATA = 1'b1
    } w_state_t;

    // Width of a counter that must hold 0..max_outstanding inclusive.
    function automatic int OUT_W(input int max_outstanding);
        return $clog2(max_outstanding) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_wr_len_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axi4_wr_len_fifo
// Brief    : Synchronous first-word-fall-through FIFO holding burst lengths;
//            exposes the head and the entry behind it for zero-bubble reloads.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_wr_len_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [WIDTH-1:0] o_next,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_multi
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_ptr_w-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_ptr_w-1:0] w_rd_next;
    logic [c_cnt_w-1:0] r_count_q, w_count_d;
    logic               w_do_push, w_do_pop;

    assign o_empty = (r_count_q == '0);
    assign o_full  = (r_count_q == c_depth);
    assign o_multi = (r_count_q > c_cnt_one);

    // Simultaneous push/pop is legal at both extremes; occupancy stays put.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && (!o_empty || i_push);

    assign w_rd_next = r_rd_ptr_q + c_ptr_one;
    assign o_head    = r_mem_q[r_rd_ptr_q];
    assign o_next    = r_mem_q[w_rd_next];

    always_comb begin
        w_rd_ptr_d = r_rd_ptr_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_count_d  = r_count_q;
        if (w_do_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_ptr_one;
        end
        if (w_do_pop) begin
            w_rd_ptr_d = w_rd_next;
        end
        if (w_do_push && !w_do_pop) begin
            w_count_d = r_count_q + c_cnt_one;
        end else if (!w_do_push && w_do_pop) begin
            w_count_d = r_count_q - c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr_q <= '0;
            r_wr_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_rd_ptr_q <= w_rd_ptr_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_q[r_wr_ptr_q] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4_wr_fifo_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : axi4_wr_fifo_sequencer
// Brief    : Sequences AW/W/B write FIFOs onto an AXI4 master write port,
//            generating WLAST and bounding outstanding bursts.
//            Define AXI4_WR_SEQ_CHECK_EN to build the sticky protocol checks.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_wr_fifo_sequencer
    import axi4_wr_seq_pkg::*;
#(
    parameter int LEN_W           = 8,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              aw_rd_empty,
    output logic                              aw_rd_en,
    input  logic [LEN_W-1:0]                  aw_len,
    output logic                              m_awvalid,
    input  logic                              m_awready,
    input  logic                              w_rd_empty,
    output logic                              w_rd_en,
    input  logic                              w_last,
    output logic                              m_wvalid,
    input  logic                              m_wready,
    output logic                              m_wlast,
    input  logic                              m_bvalid,
    output logic                              m_bready,
    input  logic                              b_wr_full,
    output logic                              b_wr_en,
    output logic [OUT_W(MAX_OUTSTANDING)-1:0] outstanding,
    output logic                              wlast_err,
    output logic                              b_err
);

    localparam int c_out_w = OUT_W(MAX_OUTSTANDING);
    localparam logic [c_out_w-1:0] c_max_out  = c_out_w'(MAX_OUTSTANDING);
    localparam logic [c_out_w-1:0] c_out_one  = c_out_w'(1);
    localparam logic [LEN_W-1:0]   c_len_one  = LEN_W'(1);
    localparam logic [LEN_W-1:0]   c_len_zero = '0;

    w_state_t           r_state_q, w_state_d;
    logic [LEN_W-1:0]   r_beat_cnt_q, w_beat_cnt_d;
    logic [c_out_w-1:0] r_outstanding_q, w_outstanding_d;
    logic               r_rst_hold_q;
    logic               w_gate, w_in_data;
    logic               w_lenq_empty, w_lenq_full, w_lenq_multi, w_lenq_pop;
    logic [LEN_W-1:0]   w_lenq_head, w_lenq_next;

    // Outputs stay quiet during reset and for one cycle after it.
    assign w_gate = areset || r_rst_hold_q;

    assign m_awvalid = !w_gate && !aw_rd_empty && (r_outstanding_q < c_max_out) && !w_lenq_full;
    assign aw_rd_en  = m_awvalid && m_awready;

    assign w_in_data  = !w_gate && (r_state_q == W_DATA);
    assign m_wvalid   = w_in_data && !w_rd_empty;
    assign w_rd_en    = m_wvalid && m_wready;
    assign m_wlast    = w_in_data && (r_beat_cnt_q == c_len_zero);
    assign w_lenq_pop = w_rd_en && m_wlast;

    assign m_bready    = !w_gate && !b_wr_full;
    assign b_wr_en     = m_bvalid && m_bready;
    assign outstanding = w_gate ? '0 : r_outstanding_q;

    axi4_wr_len_fifo #(
        .WIDTH (LEN_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_len_fifo (
        .clk     (aclk),
        .rst     (areset),
        .i_push  (aw_rd_en),
        .i_data  (aw_len),
        .i_pop   (w_lenq_pop),
        .o_head  (w_lenq_head),
        .o_next  (w_lenq_next),
        .o_empty (w_lenq_empty),
        .o_full  (w_lenq_full),
        .o_multi (w_lenq_multi)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_beat_cnt_d = r_beat_cnt_q;
        case (r_state_q)
            W_IDLE: begin
                if (!w_lenq_empty) begin
                    w_beat_cnt_d = w_lenq_head;
                    w_state_d    = W_DATA;
                end
            end
            W_DATA: begin
                if (w_rd_en) begin
                    if (r_beat_cnt_q != c_len_zero) begin
                        w_beat_cnt_d = r_beat_cnt_q - c_len_one;
                    // Next burst is either already queued or being pushed right now.
                    end else if (w_lenq_multi) begin
                        w_beat_cnt_d = w_lenq_next;
                    end else if (aw_rd_en) begin
                        w_beat_cnt_d = aw_len;
                    end else begin
                        w_state_d = W_IDLE;
                    end
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        w_outstanding_d = r_outstanding_q;
        if (aw_rd_en && !b_wr_en) begin
            w_outstanding_d = r_outstanding_q + c_out_one;
        end else if (!aw_rd_en && b_wr_en && (r_outstanding_q != '0)) begin
            w_outstanding_d = r_outstanding_q - c_out_one;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q       <= W_IDLE;
            r_beat_cnt_q    <= '0;
            r_outstanding_q <= '0;
            r_rst_hold_q    <= 1'b1;
        end else begin
            r_state_q       <= w_state_d;
            r_beat_cnt_q    <= w_beat_cnt_d;
            r_outstanding_q <= w_outstanding_d;
            r_rst_hold_q    <= 1'b0;
        end
    end

`ifdef AXI4_WR_SEQ_CHECK_EN
    logic r_wlast_err_q, w_wlast_err_d;
    logic r_b_err_q, w_b_err_d;

    always_comb begin
        w_wlast_err_d = r_wlast_err_q || (w_rd_en && (w_last != m_wlast));
        w_b_err_d     = r_b_err_q || (b_wr_en && (r_outstanding_q == '0));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wlast_err_q <= 1'b0;
            r_b_err_q     <= 1'b0;
        end else begin
            r_wlast_err_q <= w_wlast_err_d;
            r_b_err_q     <= w_b_err_d;
        end
    end

    assign wlast_err = !w_gate && r_wlast_err_q;
    assign b_err     = !w_gate && r_b_err_q;
`else
    logic w_unused_w_last;
    assign w_unused_w_last = w_last;
    assign wlast_err       = 1'b0;
    assign b_err           = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi4_wr_fifo_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for axi4_wr_fifo_sequencer: randomized FIFO/handshake
// environment against a burst-level reference model.
module tb_axi4_wr_fifo_sequencer;

    localparam int LEN_W = 8;
    localparam int MAXO  = 8;

    logic       clk = 1'b0;
    logic       areset;
    logic       aw_rd_empty, aw_rd_en, m_awvalid, m_awready;
    logic [7:0] aw_len;
    logic       w_rd_empty, w_rd_en, w_last, m_wvalid, m_wready, m_wlast;
    logic       m_bvalid, m_bready, b_wr_full, b_wr_en;
    logic [3:0] outstanding;
    logic       wlast_err, b_err;

    always #5 clk = ~clk;

    axi4_wr_fifo_sequencer #(.LEN_W(LEN_W), .MAX_OUTSTANDING(MAXO)) dut (
        .aclk(clk), .areset(areset),
        .aw_rd_empty(aw_rd_empty), .aw_rd_en(aw_rd_en), .aw_len(aw_len),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .w_rd_empty(w_rd_empty), .w_rd_en(w_rd_en), .w_last(w_last),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .b_wr_full(b_wr_full), .b_wr_en(b_wr_en),
        .outstanding(outstanding), .wlast_err(wlast_err), .b_err(b_err)
    );

    typedef struct {int left; int hs;} burst_t;

    // Stimulus contents of the external FIFOs and the expected WLAST stream.
    logic [7:0] aw_src[$];
    bit         w_src[$];
    bit         exp_beats[$];
    // Reference model: bursts accepted on AW and not yet finished on W.
    burst_t     burst_q[$];
    int         out_m = 0, b_pend = 0, last_end = -100, beats_seen = 0;
    bit         exp_wl_err = 0, exp_b_err = 0, rst_prev = 0;
    int         cyc = 0;
    int         n_tests = 0, n_fail = 0;

    int k_awr = 100, k_wr = 100, k_stall = 0, k_full = 0;
    bit k_b_en = 1, k_spur = 0;

    bit m_exp_awv, m_active, m_exp_last;
    int m_lenq_n;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // First cycle the head burst may transfer: right after the previous burst
    // if it was already queued, otherwise two cycles after its AW handshake.
    function automatic int head_start();
        if (burst_q[0].hs <= last_end) return last_end + 1;
        return burst_q[0].hs + 2;
    endfunction

    always @(negedge clk) begin
        if (areset || rst_prev) begin
            check("reset_outputs",
                  {m_awvalid, aw_rd_en, m_wvalid, w_rd_en, m_wlast, m_bready, b_wr_en,
                   wlast_err, b_err, outstanding}, 64'd0);
            burst_q.delete(); exp_beats.delete(); aw_src.delete(); w_src.delete();
            out_m = 0; b_pend = 0; last_end = -100; beats_seen = 0;
            exp_wl_err = 0; exp_b_err = 0;
        end else begin
            check("wlast_err", wlast_err, exp_wl_err);
            check("b_err", b_err, exp_b_err);
            check("outstanding", outstanding, out_m);
            m_lenq_n  = burst_q.size();
            m_exp_awv = !aw_rd_empty && (out_m < MAXO) && (m_lenq_n < MAXO);
            check("m_awvalid", m_awvalid, m_exp_awv);
            check("aw_rd_en", aw_rd_en, m_exp_awv && m_awready);
            m_active = (m_lenq_n > 0) && (cyc >= head_start());
            check("m_wvalid", m_wvalid, m_active && !w_rd_empty);
            check("w_rd_en", w_rd_en, m_active && !w_rd_empty && m_wready);
            check("m_bready", m_bready, !b_wr_full);
            check("b_wr_en", b_wr_en, m_bvalid && !b_wr_full);
            if (w_rd_en && exp_beats.size() > 0 && m_lenq_n > 0) begin
                m_exp_last = exp_beats.pop_front();
                check("m_wlast", m_wlast, m_exp_last);
`ifdef AXI4_WR_SEQ_CHECK_EN
                if (w_last != m_exp_last) exp_wl_err = 1;
`endif
                if (w_src.size() > 0) void'(w_src.pop_front());
                beats_seen++;
                burst_q[0].left--;
                if (burst_q[0].left == 0) begin
                    void'(burst_q.pop_front());
                    last_end = cyc;
                    b_pend++;
                end
            end
            if (aw_rd_en && aw_src.size() > 0) begin
                burst_q.push_back('{int'(aw_src[0]) + 1, cyc});
                void'(aw_src.pop_front());
            end
            if (b_wr_en) begin
`ifdef AXI4_WR_SEQ_CHECK_EN
                if (out_m == 0) exp_b_err = 1;
`endif
                if (b_pend > 0) b_pend--;
            end
            if (aw_rd_en && !b_wr_en) out_m++;
            else if (!aw_rd_en && b_wr_en && out_m > 0) out_m--;
        end
        rst_prev = areset;
    end

    task automatic step();
        @(posedge clk);
        #1;
        aw_rd_empty = (aw_src.size() == 0);
        aw_len      = (aw_src.size() > 0) ? aw_src[0] : 8'($urandom);
        w_rd_empty  = (w_src.size() == 0) || ($urandom_range(99) < k_stall);
        w_last      = (w_src.size() > 0) ? w_src[0] : 1'b0;
        m_awready   = ($urandom_range(99) < k_awr);
        m_wready    = ($urandom_range(99) < k_wr);
        b_wr_full   = ($urandom_range(99) < k_full);
        m_bvalid    = ((b_pend > 0) && k_b_en) || k_spur;
    endtask

    task automatic push_burst(input int len, input int bad);
        aw_src.push_back(8'(len));
        for (int i = 0; i <= len; i++) begin
            w_src.push_back((i == len) ^ (i == bad));
            exp_beats.push_back(i == len);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (!(aw_src.size() == 0 && burst_q.size() == 0 && b_pend == 0) && n < budget) begin
            step();
            n++;
        end
        n_tests++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s: not idle after %0d cycles", name, n);
        end
        repeat (2) step();
    endtask

    task automatic friendly();
        k_awr = 100; k_wr = 100; k_stall = 0; k_full = 0; k_b_en = 1; k_spur = 0;
    endtask

    initial begin
        int base, n;
        areset = 1; aw_rd_empty = 1; aw_len = 0; w_rd_empty = 1; w_last = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; b_wr_full = 0;
        repeat (3) step();
        areset = 0;
        step();

        // Single len=3 burst
        push_burst(3, -1);
        wait_idle(200, "single_burst");

        // Back-to-back len=0 then len=1
        push_burst(0, -1);
        push_burst(1, -1);
        wait_idle(200, "back_to_back");

        // Outstanding limit
        k_b_en = 0;
        repeat (9) push_burst(0, -1);
        repeat (40) step();
        check("aw_blocked_9th", aw_src.size(), 1);
        check("outstanding_at_max", outstanding, MAXO);
        k_b_en = 1;
        wait_idle(300, "outstanding_limit");

        // B backpressure
        k_b_en = 0;
        push_burst(2, -1);
        repeat (20) step();
        k_full = 100; k_b_en = 1;
        repeat (10) step();
        check("bp_out_held", outstanding, 1);
        k_full = 0;
        repeat (2) step();
        check("bp_drained", outstanding, 0);
        wait_idle(100, "backpressure");

        // Bad w_last on beat 2, then a B with nothing outstanding
        push_burst(3, 1);
        wait_idle(200, "bad_wlast");
        k_spur = 1;
        step();
        k_spur = 0;
        repeat (2) step();
`ifdef AXI4_WR_SEQ_CHECK_EN
        check("wlast_err_sticky", wlast_err, 1);
        check("b_err_set", b_err, 1);
`else
        check("wlast_err_tied", wlast_err, 0);
        check("b_err_tied", b_err, 0);
`endif
        check("spur_b_saturates", outstanding, 0);

        // Randomized traffic
        for (int it = 0; it < 1500; it++) begin
            if (it % 100 == 0) begin
                k_awr   = $urandom_range(30, 100);
                k_wr    = $urandom_range(30, 100);
                k_stall = $urandom_range(0, 40);
                k_full  = $urandom_range(0, 50);
                k_b_en  = ($urandom_range(3) != 0);
            end
            if (aw_src.size() < 4 && $urandom_range(3) == 0)
                push_burst($urandom_range(0, 15), -1);
            step();
        end
        friendly();
        wait_idle(1000, "random_drain");

        // Reset after beat 2 of a len=7 burst
        push_burst(7, -1);
        base = beats_seen;
        n = 0;
        while (beats_seen < base + 2 && n < 100) begin
            step();
            n++;
        end
        check("mid_burst_reached", beats_seen, base + 2);
        areset = 1;
        repeat (2) step();
        areset = 0;
        repeat (3) step();
        check("post_rst_out", outstanding, 0);
        check("post_rst_errs", {wlast_err, b_err}, 0);
        push_burst(1, -1);
        wait_idle(200, "post_reset_burst");
        check("post_rst_beats", beats_seen, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
